// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: write-back control bundle layout and
// architectural register constants used by the WB stage and the register file.
package mips_pkg;

  localparam int CTRL_W     = 18;
  localparam int CTRL_RF_EN = 8;
  localparam int CTRL_HI_EN = 1;
  localparam int CTRL_LO_EN = 0;
  localparam int REG_ZERO   = 0;

  // Bits of the control bundle that the register file actually consumes
  localparam logic [CTRL_W-1:0] CTRL_USED_MASK =
      (CTRL_W'(1) << CTRL_RF_EN) |
      (CTRL_W'(1) << CTRL_HI_EN) |
      (CTRL_W'(1) << CTRL_LO_EN);

  // Decoded write-back enables
  typedef struct packed {
    logic rf_en;
    logic hi_en;
    logic lo_en;
  } wb_en_t;

endpackage

// File: rtl/wb_hilo_unit.sv
// HI/LO special registers with same-cycle write bypass on their outputs.
module wb_hilo_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_hi_en,
  input  logic              i_lo_en,
  input  logic [DATA_W-1:0] i_hi_data,
  input  logic [DATA_W-1:0] i_lo_data,
  output logic [DATA_W-1:0] o_hi_data,
  output logic [DATA_W-1:0] o_lo_data
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // Independent HI/LO loads; reset wins over any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_en) r_hi <= i_hi_data;
      if (i_lo_en) r_lo <= i_lo_data;
    end
  end

  // Bypass: a write in flight is visible in the same cycle
  always_comb begin
    o_hi_data = i_hi_en ? i_hi_data : r_hi;
    o_lo_data = i_lo_en ? i_lo_data : r_lo;
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: 32-entry GPR array with two bypassed read ports,
// HI/LO pair, and a diagnostic count of committed GPR writes.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] wb_control,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] wb_hi_data,
  input  logic [DATA_W-1:0] wb_lo_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] hi_data,
  output logic [DATA_W-1:0] lo_data,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [15:0]       r_wr_count;
  wb_en_t            w_en;
  logic              w_gpr_commit;
  logic              w_ctrl_unused;

  // Decode the enables out of the control bundle; other bits are don't-care
  always_comb begin
    w_en.rf_en    = wb_control[CTRL_RF_EN];
    w_en.hi_en    = wb_control[CTRL_HI_EN];
    w_en.lo_en    = wb_control[CTRL_LO_EN];
    w_gpr_commit  = w_en.rf_en && (wb_dest != ADDR_W'(REG_ZERO));
    w_ctrl_unused = ^(wb_control & ~CTRL_USED_MASK);
  end

  // GPR storage and write counter; r0 writes are dropped and not counted
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
    end else if (w_gpr_commit) begin
      r_regs[wb_dest] <= wb_data;
      r_wr_count      <= r_wr_count + 16'd1;
    end
  end

  // Read port A: r0 hard zero, then bypass of the in-flight write, then storage
  always_comb begin
    rs_data = r_regs[rs_addr];
    if (rs_addr == ADDR_W'(REG_ZERO))            rs_data = '0;
    else if (w_en.rf_en && (wb_dest == rs_addr)) rs_data = wb_data;
  end

  // Read port B: same priority as port A
  always_comb begin
    rt_data = r_regs[rt_addr];
    if (rt_addr == ADDR_W'(REG_ZERO))            rt_data = '0;
    else if (w_en.rf_en && (wb_dest == rt_addr)) rt_data = wb_data;
  end

  assign wr_count = r_wr_count;

  wb_hilo_unit #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk       (clk),
    .reset     (reset),
    .i_hi_en   (w_en.hi_en),
    .i_lo_en   (w_en.lo_en),
    .i_hi_data (wb_hi_data),
    .i_lo_data (wb_lo_data),
    .o_hi_data (hi_data),
    .o_lo_data (lo_data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expected read-port values
// computed from a behavioural register model; a monitor pops and compares.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [17:0] wb_control;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [31:0] wb_hi_data;
  logic [31:0] wb_lo_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic [15:0] wr_count;

  wb_regfile #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_control (wb_control),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .wb_hi_data (wb_hi_data),
    .wb_lo_data (wb_lo_data),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .hi_data    (hi_data),
    .lo_data    (lo_data),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: architectural state only
  logic [31:0] m_regs [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int unsigned m_cnt;

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic rf,
                                         input logic [4:0] dest, input logic [31:0] d);
    if (a == 5'd0) return 32'd0;
    if (rf && dest == a) return d;
    return m_regs[a];
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h at %0t", nm, fld, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive, predict, push, then advance the model
  task automatic step(input string nm, input logic rst, input logic rf,
                      input logic hen, input logic len, input logic [4:0] dest,
                      input logic [31:0] d, input logic [31:0] hd, input logic [31:0] ld,
                      input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    logic [17:0] ctrl;
    @(posedge clk);
    #1;
    ctrl = 18'($urandom);
    ctrl[8] = rf;
    ctrl[1] = hen;
    ctrl[0] = len;
    reset      = rst;
    wb_control = ctrl;
    wb_dest    = dest;
    wb_data    = d;
    wb_hi_data = hd;
    wb_lo_data = ld;
    rs_addr    = ra;
    rt_addr    = rb;
    e.name = nm;
    e.rs   = m_read(ra, rf, dest, d);
    e.rt   = m_read(rb, rf, dest, d);
    e.hi   = hen ? hd : m_hi;
    e.lo   = len ? ld : m_lo;
    e.cnt  = 16'(m_cnt);
    q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_hi  = '0;
      m_lo  = '0;
      m_cnt = 0;
    end else begin
      if (rf && dest != 5'd0) begin
        m_regs[dest] = d;
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (hen) m_hi = hd;
      if (len) m_lo = ld;
    end
  endtask

  // Monitor: every cycle the DUT presents combinational outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.name, "rs",  rs_data, e.rs);
        chk(e.name, "rt",  rt_data, e.rt);
        chk(e.name, "hi",  hi_data, e.hi);
        chk(e.name, "lo",  lo_data, e.lo);
        chk(e.name, "cnt", {16'd0, wr_count}, {16'd0, e.cnt});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] last;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_hi = '0; m_lo = '0; m_cnt = 0;
    reset = 1'b1; wb_control = '0; wb_dest = '0; wb_data = '0;
    wb_hi_data = '0; wb_lo_data = '0; rs_addr = '0; rt_addr = '0;
    @(posedge clk);

    step("rst",    1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
    step("rd0",    0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
    step("w7",     0, 1, 0, 0, 5'd7, 32'hDEADBEEF, 32'h0, 32'h0, 5'd7, 5'd0);
    step("h7",     0, 0, 0, 0, 5'd7, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);
    step("w0a",    0, 1, 0, 0, 5'd0, 32'h12345678, 32'h0, 32'h0, 5'd0, 5'd0);
    step("w0b",    0, 1, 0, 0, 5'd0, 32'h12345678, 32'h0, 32'h0, 5'd0, 5'd0);
    step("hilo",   0, 1, 1, 1, 5'd3, 32'h33333333, 32'hAAAA0000, 32'h0000BBBB, 5'd3, 5'd3);
    step("hilo_h", 0, 0, 0, 0, 5'd3, 32'h0, 32'h1, 32'h2, 5'd3, 5'd7);
    step("rst_w9", 1, 1, 0, 0, 5'd9, 32'h99999999, 32'h0, 32'h0, 5'd9, 5'd9);
    step("r9",     0, 0, 0, 0, 5'd9, 32'h0, 32'h0, 32'h0, 5'd9, 5'd3);

    last = '0;
    for (int i = 0; i < 65536; i++) begin
      last = $urandom;
      step("wrap", 0, 1, 0, 0, 5'd1, last, 32'h0, 32'h0, 5'd1, 5'($urandom));
    end
    step("wrap_end", 0, 0, 0, 0, 5'd1, 32'h0, 32'h0, 32'h0, 5'd1, 5'd1);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] dest;
      logic [4:0] ra;
      logic [4:0] rb;
      dest = 5'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom);
      step("rand", ($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom),
           1'($urandom), dest, $urandom, $urandom, $urandom, ra, rb);
    end

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending entries", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Architectural state sink at the write-back end of the MIPS pipeline. It consumes the 18-bit control bundle and result data emitted by the write-back stage, commits them into the 32×32 general-purpose register file and the HI/LO pair, and serves the decode stage's two source-operand reads. Same-cycle write-to-read bypass removes the WB→ID structural hazard.

## Interface

Parameters:
- DATA_W, 32, width of every register and data port.
- ADDR_W, 5, register address width; the file depth is 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- wb_control  in  18  control bundle from the write-back stage. Bit 8 is rf_enable, bit 1 is hi_enable, bit 0 is lo_enable. All other bits are ignored.
- wb_dest  in  ADDR_W  GPR destination index.
- wb_data  in  DATA_W  GPR write data.
- wb_hi_data  in  DATA_W  HI write data.
- wb_lo_data  in  DATA_W  LO write data.
- rs_addr  in  ADDR_W  decode read port A index.
- rt_addr  in  ADDR_W  decode read port B index.
- rs_data  out  DATA_W  port A data.
- rt_data  out  DATA_W  port B data.
- hi_data  out  DATA_W  current HI, bypassed.
- lo_data  out  DATA_W  current LO, bypassed.
- wr_count  out  16  count of committed GPR writes. Diagnostic only.

## Operation

- GPR write:
  - Occurs on posedge clk when rf_enable=1 and wb_dest≠0.
  - regs[wb_dest] takes wb_data.
  - A write to r0 is discarded, and wr_count does not increment for it.
- r0 always reads 0, whether or not a write to r0 is present in the same cycle.
- HI and LO writes are independent:
  - hi_enable=1 loads HI from wb_hi_data.
  - lo_enable=1 loads LO from wb_lo_data.
  - Both may assert in the same cycle, with or without a GPR write.
- Reads are combinational. Priority for rs_data, and identically for rt_data:
  1. rs_addr==0 gives 0.
  2. Otherwise, if rf_enable and wb_dest==rs_addr, the output is wb_data (bypass).
  3. Otherwise, the output is regs[rs_addr].
- hi_data is wb_hi_data when hi_enable=1, else the stored HI. lo_data follows the same rule with lo_enable, wb_lo_data and stored LO.
- Both read ports may address the same register; both then return the same value, including the bypassed value.
- wr_count increments by 1 per committed GPR write and wraps from 0xFFFF to 0x0000.
- Reset:
  - All 32 GPRs, HI, LO and wr_count clear to 0 in the same cycle.
  - Reset has priority over any write asserted in that cycle; the write is lost.
  - Bypass stays active while reset=1, so read outputs reflect the live inputs even during reset.
- Upstream is responsible for valid bits: while reset is asserted, the WB stage drives rf_enable, hi_enable and lo_enable to 0, and so are neither acted on nor bypassed.

## Timing

- Write latency: data is stored at the posedge where enables are sampled, and is readable from storage from the next cycle.
- Read latency: 0 cycles, combinational. With bypass, a write presented in cycle N is visible on the read outputs in cycle N.
- Output values after reset: rs_data, rt_data, hi_data and lo_data read 0 for any address until the first write. wr_count reads 0.
- No handshake: every enabled write is accepted every cycle, and there is no backpressure.
- Combinational path: wb_* inputs to read outputs goes through bypass only, with one comparator and one mux per port.

## Structure

- Shared package mips_pkg holds:
  - constants CTRL_RF_EN=8, CTRL_HI_EN=1, CTRL_LO_EN=0;
  - REG_ZERO=0;
  - the control-bundle width of 18.
  
  The WB stage and this block both import it.
- Sub-module wb_hilo_unit holds the HI/LO registers and their bypass muxes.
- The GPR array, read muxes and wr_count live at the top level.

## Test plan

- Reset, then read rs=5 and rt=31: both return 0, and wr_count=0.
- Write r7=0xDEADBEEF. In the same cycle read rs=7: returns 0xDEADBEEF through bypass. The next cycle, with rf_enable=0, rs=7 still returns 0xDEADBEEF. wr_count=1.
- Write r0=0x12345678 with rs=0 and rt=0 in that cycle and the next: both ports always read 0, and wr_count stays unchanged.
- hi_enable=1 and lo_enable=1 with HI=0xAAAA0000 and LO=0x0000BBBB, alongside a GPR write to r3: all three values are visible the same cycle and persist afterwards.
- Write r9 while reset=1: the bypass shows the value that cycle, but the next cycle r9 reads 0 and wr_count=0.
- Issue 65536 consecutive writes to r1: wr_count wraps to 0, and r1 holds the last data written.
